// File: rtl/contador_if.sv
// Direction/count bundle of the up/down counter.
// The master drives the direction and observes the count; the counter is the slave.
interface contador_if #(
    parameter int unsigned WIDTH = 8
);
    logic             up_down;
    logic [WIDTH-1:0] cuenta;

    modport master (
        output up_down,
        input  cuenta
    );

    modport slave (
        input  up_down,
        output cuenta
    );
endinterface

// File: rtl/contador.sv
// Free-running WIDTH-bit up/down counter.
// The count wraps modulo 2^WIDTH in both directions; only reset can force a value.
module contador #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    contador_if.slave  cnt_if
);
    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] cuenta_q, cuenta_d;

    // The carry/borrow falls off the top bit, which gives the wrap-around.
    always_comb begin
        cuenta_d = cuenta_q;
        if (cnt_if.up_down) begin
            cuenta_d = cuenta_q + One;
        end else begin
            cuenta_d = cuenta_q - One;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cnt_if.cuenta = cuenta_q;

    // An unknown direction at a counting edge is illegal stimulus.
    a_up_down_known : assert property (
        @(posedge clk) disable iff (!rst) !$isunknown(cnt_if.up_down)
    );
endmodule

// File: tb/tb_contador.sv
// Self-checking bench for contador: an arithmetic reference model compared every cycle,
// plus hand-computed literal checkpoints for reset, wrap-around and direction changes.
module tb_contador;
    localparam int unsigned WIDTH = 8;
    localparam int          Modulus = 1 << WIDTH;

    logic clk;
    logic rst;
    logic clk_en;
    logic chk_en;
    int   checks;
    int   errors;
    int   model;

    contador_if #(.WIDTH(WIDTH)) cnt_if ();

    contador #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .cnt_if (cnt_if)
    );

    // Gated clock so reset can be checked with the clock idle.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input int exp);
        checks++;
        if (act !== WIDTH'(exp)) begin
            errors++;
            $display("FAIL %s: cuenta=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: reset forces 0, each rising edge steps by +/-1 modulo 2^WIDTH.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model = 0;
        end else if (cnt_if.up_down) begin
            model = (model + 1) % Modulus;
        end else begin
            model = (model + Modulus - 1) % Modulus;
        end
    end

    always @(negedge clk) begin
        if (chk_en) check("cycle", cnt_if.cuenta, model);
    end

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_reset();
        #1 rst = 0;
        #1 check("async_reset", cnt_if.cuenta, 0);
        #1 rst = 1;
        #1 check("release_holds", cnt_if.cuenta, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model  = 0;
        clk    = 0;
        clk_en = 0;
        chk_en = 0;
        rst    = 1;
        cnt_if.up_down = 1;

        // Reset with clock idle, then clock toggling while held in reset.
        #3 rst = 0;
        #1 check("reset_no_clock", cnt_if.cuenta, 0);
        chk_en = 1;
        clk_en = 1;
        edges(4);
        check("reset_held", cnt_if.cuenta, 0);
        cnt_if.up_down = 0;
        edges(2);
        check("reset_held_down", cnt_if.cuenta, 0);

        // Count up 151 edges.
        cnt_if.up_down = 1;
        rst = 1;
        #1 check("release_no_change", cnt_if.cuenta, 0);
        @(negedge clk);
        check("first_edge", cnt_if.cuenta, 1);
        edges(150);
        check("count_151", cnt_if.cuenta, 151);

        // Reset mid-count, resume from 0.
        pulse_reset();
        edges(1);
        check("resume_1", cnt_if.cuenta, 1);
        edges(1);
        check("resume_2", cnt_if.cuenta, 2);

        // Full range and up wrap.
        pulse_reset();
        edges(255);
        check("full_255", cnt_if.cuenta, 255);
        edges(1);
        check("wrap_up_0", cnt_if.cuenta, 0);
        edges(255);
        check("again_255", cnt_if.cuenta, 255);

        // Direction change between edges has no combinational effect.
        cnt_if.up_down = 0;
        #2 check("dir_change_holds", cnt_if.cuenta, 255);
        edges(1);
        check("down_254", cnt_if.cuenta, 254);
        edges(1);
        check("down_253", cnt_if.cuenta, 253);
        edges(253);
        check("down_0", cnt_if.cuenta, 0);
        edges(1);
        check("wrap_down_255", cnt_if.cuenta, 255);

        // Reset while counting down.
        pulse_reset();
        cnt_if.up_down = 1;
        edges(10);
        check("reach_10", cnt_if.cuenta, 10);

        // Alternate direction each edge; glitch up_down mid-cycle to prove edge sampling.
        for (int i = 0; i < 4; i++) begin
            cnt_if.up_down = (i % 2 == 0) ? 1'b1 : 1'b0;
            #2 cnt_if.up_down = ~cnt_if.up_down;
            #1 cnt_if.up_down = ~cnt_if.up_down;
            @(negedge clk);
            check("toggle", cnt_if.cuenta, (i % 2 == 0) ? 11 : 10);
        end

        chk_en = 0;
        clk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
